affine_loop_gen: RTL

// - Parametrised nested-loop index and affine address generator for the CGRA fabric.
// - Replaces hand-mapped const_unit + ALU(add/mul) + reg_unit + compare chains that produce

---
 rtl/affine_loop_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/affine_loop_gen.sv
`default_nettype none
// ============================================================================
// affine_loop_gen : nested-loop index and base+sum(idx*stride) address stream
// Revision 1.0
// ============================================================================
module affine_loop_gen #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [WIDTH-1:0]       base,
  input  logic [DEPTH*CNT_W-1:0] bound,
  input  logic [DEPTH*WIDTH-1:0] stride,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_addr,
  output logic [DEPTH*CNT_W-1:0] out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]       r_base;
  logic [DEPTH*CNT_W-1:0] r_bound;
  logic [DEPTH*WIDTH-1:0] r_stride;
  logic [DEPTH*CNT_W-1:0] r_idx;
  logic [WIDTH-1:0]       r_addr;
  logic                   r_valid;
  logic                   r_last;

  logic [DEPTH*CNT_W-1:0] w_idx_nxt;
  logic [WIDTH-1:0]       w_addr_nxt;
  logic                   w_last_nxt;
  logic                   w_carry;
  logic [CNT_W-1:0]       w_bk;
  logic [CNT_W-1:0]       w_ik;
  logic [CNT_W-1:0]       w_nk;
  logic                   w_start_zero;
  logic                   w_start_last;
  logic                   w_take;

  assign w_take = en & r_valid & out_ready;

  // Odometer step plus the address of the stepped indices, all from latched config.
  always_comb begin : p_step
    w_idx_nxt  = r_idx;
    w_addr_nxt = r_base;
    w_last_nxt = 1'b1;
    w_carry    = 1'b1;
    w_bk       = '0;
    w_ik       = '0;
    w_nk       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_bk = r_bound[k*CNT_W +: CNT_W];
      w_ik = r_idx[k*CNT_W +: CNT_W];
      w_nk = w_ik;
      if (w_carry) begin
        if (w_ik == w_bk - C_ONE) begin
          w_nk = '0;
        end else begin
          w_nk = w_ik + C_ONE;
        end
        w_carry = (w_ik == w_bk - C_ONE);
      end
      w_idx_nxt[k*CNT_W +: CNT_W] = w_nk;
      w_last_nxt = w_last_nxt & (w_nk == w_bk - C_ONE);
      w_addr_nxt = w_addr_nxt + (WIDTH'(w_nk) * r_stride[k*WIDTH +: WIDTH]);
    end
  end

  always_comb begin : p_start_chk
    w_start_zero = 1'b0;
    w_start_last = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (bound[k*CNT_W +: CNT_W] == '0) begin
        w_start_zero = 1'b1;
      end
      if (bound[k*CNT_W +: CNT_W] != C_ONE) begin
        w_start_last = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = w_start_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_take && r_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base   <= '0;
      r_bound  <= '0;
      r_stride <= '0;
      r_idx    <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= base;
            r_bound  <= bound;
            r_stride <= stride;
            r_idx    <= '0;
            r_addr   <= base;
            r_valid  <= ~w_start_zero;
            r_last   <= ~w_start_zero & w_start_last;
          end
        end
        S_RUN: begin
          if (w_take) begin
            // Indices and address stay on the final beat once the nest ends.
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= w_idx_nxt;
              r_addr <= w_addr_nxt;
              r_last <= w_last_nxt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire
